piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out loader that feeds the s_in input of the 4-bit SISO shift register.
//   Accepts one WIDTH-bit word per valid/ready handshake and emits it one bit per clk cycle on s_out.
//   Back-to-back words stream with no idle cycle between them.
// PARAMETERS
//   WIDTH       4   data bits per word (>=1)
//   MSB_FIRST   1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//   IDLE_LEVEL  0   s_out level while no word is being sent
// PORTS
//   clk      in   1      clock, rising-edge
//   rst      in   1      asynchronous, active-low reset
//   p_data   in   WIDTH  parallel word; captured on handshake
//   p_valid  in   1      p_data is valid
//   p_ready  out  1      block can accept a word this cycle
//   s_out    out  1      serial bit stream, connects to the SISO s_in
//   s_valid  out  1      s_out carries a data (or parity) bit
//   busy     out  1      a word is in flight
//   done     out  1      1-cycle pulse during the final serial bit of a word
// BEHAVIOUR
//   - rst low (async): state=IDLE, shreg=0, cnt=0, s_out=IDLE_LEVEL, s_valid=0, busy=0, done=0, p_ready=0.
//   - Outputs are registered. p_ready rises at the first clk edge after rst deasserts.
//   - FSM states: IDLE, SHIFT (plus PARITY when enabled).
//   - Handshake: a transfer occurs at a rising edge with p_valid && p_ready; p_data is latched into shreg.
//   - p_valid while p_ready=0 is ignored. Changes to p_data after acceptance have no effect.
//   - Latency: the first bit appears on s_out in the cycle after the handshake edge.
//     Each bit is held for exactly 1 cycle; WIDTH data cycles follow.
//   - IDLE -> SHIFT on handshake; cnt loads WIDTH-1 and counts down to 0.
//   - SHIFT, cnt==0 (last bit):
//     - done=1 for that cycle, and p_ready=1 for that cycle.
//     - Handshake at that edge -> stay in SHIFT with the new word; its first bit follows with no gap.
//     - No handshake at that edge -> IDLE: s_out=IDLE_LEVEL, s_valid=0, busy=0.
//   - p_ready = 1 in IDLE and in the last-bit cycle; 0 otherwise.
//   - busy = 1 whenever s_valid = 1.
//   - WIDTH=1: every SHIFT cycle is a last-bit cycle.
//   - cnt width: CNT_W=$clog2(WIDTH+1).
//   - rst asserted mid-word: the word is discarded and outputs return to reset values immediately.
//   - s_out is stable for a full cycle, so the consumer may sample it on either clock edge.
// CONFIGURATION
//   PISO_PARITY_EN defined:
//     - After the last data bit, one extra cycle (state PARITY) sends the even parity bit
//       (XOR of the word) with s_valid=1.
//     - done and p_ready move to the PARITY cycle; the word occupies WIDTH+1 cycles.
//   PISO_PARITY_EN undefined:
//     - No PARITY state; the word occupies exactly WIDTH cycles.
// STRUCTURE
//   - Shared package serial_pkg: state encodings (IDLE/SHIFT/PARITY) and the CNT_W computation.
//   - The same package is reused by the downstream deserializer.
//   - One sub-module, piso_bit_counter: loadable down-counter with a zero flag.
//   - The shift register and FSM stay in piso_serializer.
// TESTING (WIDTH=4 unless noted)
//   1. Reset, then load 4'b1010 (MSB_FIRST=1)
//      -> s_out=1,0,1,0 on cycles 1-4 after the handshake; done on cycle 4; then s_out=IDLE_LEVEL, s_valid=0.
//   2. Back-to-back 4'b1010 then 4'b0110 with p_valid held high
//      -> s_out=1,0,1,0,0,1,1,0 contiguous; p_ready high only on cycles 4 and 8.
//   3. MSB_FIRST=0, load 4'b0011
//      -> s_out=1,1,0,0; SISO s_out shows the same sequence 4 cycles later.
//   4. Drop rst low mid-word after 2 bits of 4'b1111
//      -> s_out=IDLE_LEVEL and s_valid=0 immediately; after release, the next word 4'b0001 sends cleanly.
//   5. Toggle p_valid and p_data while busy
//      -> no extra transfer occurs; the serial stream matches the originally captured word.
//   6. PISO_PARITY_EN, load 4'b1011
//      -> s_out=1,0,1,1,1 (parity=1); done on the 5th cycle; 4'b1001 gives parity 0.

Source files
------------

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the serial link: FSM state encodings and the
//   bit-counter width helper. Both the serializer and the downstream
//   deserializer import this package.
// -----------------------------------------------------------------------------
package serial_pkg;

  // PARITY is only reached when the parity bit is enabled in the build.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } serial_state_t;

  // The counter must be able to hold WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
//   Loadable down-counter with a zero flag. It tracks how many bits of the
//   current word remain after the one being sent.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-low reset (counter clears to 0)
//   i_load       in   load i_load_val (takes priority over i_dec)
//   i_load_val   in   value to load
//   i_dec        in   decrement by one (saturates at zero)
//   o_zero       out  counter is zero this cycle
//   o_zero_next  out  counter will be zero after the coming clock edge
// -----------------------------------------------------------------------------
module piso_bit_counter
  import serial_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_zero_next
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

  // Look-ahead flag lets the parent register its last-bit outputs so that
  // they line up with the bit they describe.
  assign o_zero_next = i_load ? (i_load_val == '0)
                     : i_dec  ? (r_cnt <= CNT_W'(1))
                     :          o_zero;

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out loader feeding the s_in input of a SISO shift
//   register. One WIDTH-bit word is accepted per valid/ready handshake and
//   sent one bit per clock on s_out. Back-to-back words stream without gaps:
//   p_ready is raised during the final bit so the next word can be taken on
//   the same edge that retires the current one.
//
// Parameters
//   WIDTH       data bits per word (>= 1)
//   MSB_FIRST   1: bit WIDTH-1 sent first, 0: bit 0 sent first
//   IDLE_LEVEL  s_out level while no word is being sent
//
// Build option
//   PISO_PARITY_EN  when defined, an even-parity bit (XOR of the word) is sent
//                   after the data bits; done/p_ready move to that cycle.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous, active-low reset
//   p_data   in   parallel word, captured on handshake
//   p_valid  in   p_data is valid
//   p_ready  out  a word can be accepted this cycle
//   s_out    out  serial bit stream
//   s_valid  out  s_out carries a data (or parity) bit
//   busy     out  a word is in flight
//   done     out  pulse during the final serial bit of a word
//
// All outputs are registered; they are computed from the next-state values.
// -----------------------------------------------------------------------------
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_data,
  input  logic             p_valid,
  output logic             p_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);

  serial_state_t    r_state;
  serial_state_t    w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;

  logic r_s_out, r_s_valid, r_busy, r_done, r_p_ready;
  logic w_s_out_next, w_s_valid_next, w_busy_next, w_done_next, w_p_ready_next;

  logic w_accept;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_zero;
  logic w_cnt_zero_next;

`ifdef PISO_PARITY_EN
  logic r_parity;
  logic w_parity_next;
`endif

  // r_p_ready is only high in IDLE or in the final cycle of a word, so an
  // accept can be handled uniformly regardless of the current state.
  assign w_accept = p_valid && r_p_ready;

  piso_bit_counter #(
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(WIDTH - 1)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero),
    .o_zero_next(w_cnt_zero_next)
  );

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_shreg_next = r_shreg;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
`ifdef PISO_PARITY_EN
    w_parity_next = r_parity;
`endif
    if (w_accept) begin
      w_state_next = ST_SHIFT;
      w_shreg_next = p_data;
      w_cnt_load   = 1'b1;
`ifdef PISO_PARITY_EN
      w_parity_next = ^p_data;
`endif
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (!w_cnt_zero) begin
            // Keep the bit to send next at the output end of the register.
            w_shreg_next = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
            w_cnt_dec    = 1'b1;
          end else begin
`ifdef PISO_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_IDLE;
`endif
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output values for the cycle that follows the coming edge.
  always_comb begin
    w_s_out_next   = IDLE_LEVEL;
    w_s_valid_next = 1'b0;
    w_busy_next    = 1'b0;
    w_done_next    = 1'b0;
    w_p_ready_next = 1'b1;
    case (w_state_next)
      ST_SHIFT: begin
        w_s_out_next   = MSB_FIRST ? w_shreg_next[WIDTH-1] : w_shreg_next[0];
        w_s_valid_next = 1'b1;
        w_busy_next    = 1'b1;
`ifdef PISO_PARITY_EN
        // The last data bit is followed by the parity bit, which owns done.
        w_done_next    = 1'b0;
        w_p_ready_next = 1'b0;
`else
        w_done_next    = w_cnt_zero_next;
        w_p_ready_next = w_cnt_zero_next;
`endif
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        w_s_out_next   = w_parity_next;
        w_s_valid_next = 1'b1;
        w_busy_next    = 1'b1;
        w_done_next    = 1'b1;
        w_p_ready_next = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_s_out   <= IDLE_LEVEL;
      r_s_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_p_ready <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_s_out   <= w_s_out_next;
      r_s_valid <= w_s_valid_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_p_ready <= w_p_ready_next;
`ifdef PISO_PARITY_EN
      r_parity  <= w_parity_next;
`endif
    end
  end

  assign s_out   = r_s_out;
  assign s_valid = r_s_valid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign p_ready = r_p_ready;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Two serializers share clock and reset: lane 0 is MSB-first with idle
//   level 0, lane 1 is LSB-first with idle level 1. Stimulus pushes the
//   hand-derived serial sequence of each accepted word into a per-lane queue;
//   a monitor on the falling edge pops and compares whenever s_valid is high
//   and checks idle levels otherwise.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int NB = W + PAR_EN;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] p_data0, p_data1;
  logic p_valid0, p_valid1;
  logic p_ready0, s_out0, s_valid0, busy0, done0;
  logic p_ready1, s_out1, s_valid1, busy1, done1;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .p_data(p_data0), .p_valid(p_valid0),
    .p_ready(p_ready0), .s_out(s_out0), .s_valid(s_valid0),
    .busy(busy0), .done(done0)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .p_data(p_data1), .p_valid(p_valid1),
    .p_ready(p_ready1), .s_out(s_out1), .s_valid(s_valid1),
    .busy(busy1), .done(done1)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare one lane's outputs against the head of its queue.
  task automatic mon(input int lane, input logic so, input logic sv, input logic bz,
                     input logic dn, input logic pr, input logic idle_lvl);
    exp_t e;
    int   sz;
    sz = (lane == 0) ? q0.size() : q1.size();
    chk($sformatf("lane%0d_busy", lane), bz, sv);
    if (sv) begin
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL lane%0d_extra_bit: got s_valid=1 expected no bit at %0t", lane, $time);
      end else begin
        e = (lane == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("lane%0d_s_out", lane), so, e.b);
        chk($sformatf("lane%0d_done", lane), dn, e.last);
        chk($sformatf("lane%0d_p_ready", lane), pr, e.last);
        $display("lane%0d bit s_out=%0b done=%0b p_ready=%0b at %0t", lane, so, dn, pr, $time);
      end
    end else begin
      chk($sformatf("lane%0d_idle_s_out", lane), so, idle_lvl);
      chk($sformatf("lane%0d_idle_done", lane), dn, 1'b0);
      chk($sformatf("lane%0d_idle_p_ready", lane), pr, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_s_valid0", s_valid0, 1'b0);
      chk("rst_p_ready0", p_ready0, 1'b0);
      chk("rst_s_out0", s_out0, 1'b0);
      chk("rst_s_valid1", s_valid1, 1'b0);
      chk("rst_s_out1", s_out1, 1'b1);
    end else begin
      mon(0, s_out0, s_valid0, busy0, done0, p_ready0, 1'b0);
      mon(1, s_out1, s_valid1, busy1, done1, p_ready1, 1'b1);
    end
  end

  // seq lists the expected serial bits, first-sent bit in position W-1.
  task automatic send(input int lane, input logic [W-1:0] d, input logic [W-1:0] seq,
                      input logic par);
    int   n;
    logic rdy;
    exp_t e;
    n = 0;
    if (lane == 0) begin p_data0 = d; p_valid0 = 1'b1; end
    else           begin p_data1 = d; p_valid1 = 1'b1; end
    rdy = (lane == 0) ? p_ready0 : p_ready1;
    while (!rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
      rdy = (lane == 0) ? p_ready0 : p_ready1;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL lane%0d_ready_timeout: got p_ready=0 expected 1 within 50 cycles", lane);
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        e.b    = seq[i];
        e.last = (i == 0) && (PAR_EN == 0);
        if (lane == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (PAR_EN != 0) begin
        e.b    = par;
        e.last = 1'b1;
        if (lane == 0) q0.push_back(e); else q1.push_back(e);
      end
      $display("lane%0d send data=%b", lane, d);
      @(posedge clk); #1;
    end
    // Scramble the bus after acceptance; it must have no effect.
    if (lane == 0) begin p_valid0 = 1'b0; p_data0 = W'($urandom); end
    else           begin p_valid1 = 1'b0; p_data1 = W'($urandom); end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    p_data0 = '0; p_data1 = '0;
    p_valid0 = 1'b0; p_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    chk("p_ready_before_first_edge", p_ready0, 1'b0);
    @(posedge clk); #1;
    chk("p_ready0_after_release", p_ready0, 1'b1);
    chk("p_ready1_after_release", p_ready1, 1'b1);

    // Single word, MSB first.
    send(0, 4'b1010, 4'b1010, 1'b0);
    idle(8);

    // Back-to-back with p_valid held high.
    send(0, 4'b1010, 4'b1010, 1'b0);
    send(0, 4'b0110, 4'b0110, 1'b0);
    idle(8);

    // LSB first.
    send(1, 4'b0011, 4'b1100, 1'b0);
    idle(8);
    send(1, 4'b1000, 4'b0001, 1'b1);
    idle(8);

    // Reset in the middle of a word, after two bits.
    send(0, 4'b1111, 4'b1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midword_rst_s_out", s_out0, 1'b0);
    chk("midword_rst_s_valid", s_valid0, 1'b0);
    chk("midword_rst_busy", busy0, 1'b0);
    chk("midword_rst_done", done0, 1'b0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("p_ready0_after_midword_rst", p_ready0, 1'b1);
    send(0, 4'b0001, 4'b0001, 1'b1);
    idle(8);

    // Toggle p_valid/p_data while busy; only the captured word may appear.
    send(0, 4'b1001, 4'b1001, 1'b0);
    for (int i = 0; i < NB - 1; i++) begin
      p_valid0 = (i % 2 == 0);
      p_data0  = W'($urandom);
      @(posedge clk); #1;
    end
    p_valid0 = 1'b0;
    idle(8);

    // Parity vectors (data-only in the default build).
    send(0, 4'b1011, 4'b1011, 1'b1);
    send(0, 4'b1001, 4'b1001, 1'b0);
    idle(4);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    idle(4);
    chk("lane0_queue_drained", q0.size(), 0);
    chk("lane1_queue_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
